// File: rtl/counter_pkg.sv
// Shared constants and sizing helpers for the digit counter / scan block.
// Contents:
//   DIGIT_W              width of one digit nibble
//   RADIX_BCD/RADIX_HEX  the two legal per-digit radices
//   div_width()          register width for a 0..ratio-1 divider counter
//   idx_width()          register width for a 0..n-1 scan index
package counter_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned RADIX_BCD = 10;
    localparam int unsigned RADIX_HEX = 16;

    function automatic int unsigned div_width(input int unsigned ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_counter_scan_if.sv
// Control/status bundle of digit_counter_scan.
// Signals:
//   en, up_dn, clear, load, load_val  control from the master (host logic)
//   count_val, wrap                   counter state returned to the master
//   digit_val, digit_sel              multiplexed display drive (digit_sel active low)
// Modports: master (drives control), slave (the counter).
interface digit_counter_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    import counter_pkg::*;

    logic                            en;
    logic                            up_dn;
    logic                            clear;
    logic                            load;
    logic [DIGIT_W*NUM_DIGITS-1:0]   load_val;
    logic [DIGIT_W*NUM_DIGITS-1:0]   count_val;
    logic                            wrap;
    logic [DIGIT_W-1:0]              digit_val;
    logic [NUM_DIGITS-1:0]           digit_sel;

    modport master (
        output en, up_dn, clear, load, load_val,
        input  count_val, wrap, digit_val, digit_sel
    );

    modport slave (
        input  en, up_dn, clear, load, load_val,
        output count_val, wrap, digit_val, digit_sel
    );

endinterface

// File: rtl/counter_digit.sv
// One counter digit: register with increment/decrement, ripple carry/borrow,
// synchronous clear and load (BCD loads clamp digits above 9 to 9).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear_i, load_i synchronous clear / load (clear wins)
//   load_val_i      digit value to load
//   up_i            direction, 1 = up
//   cin_i           carry (up) or borrow (down) into this digit; enables the step
//   digit_o         registered digit value
//   cout_o          carry/borrow out, combinational
module counter_digit
    import counter_pkg::*;
#(
    parameter int unsigned RADIX = RADIX_BCD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] load_val_i,
    input  logic               up_i,
    input  logic               cin_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               cout_o
);

    localparam logic [DIGIT_W-1:0] DigMax = DIGIT_W'(RADIX - 1);

    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               at_limit;

    // Limit is the value that rolls over in the current direction.
    assign at_limit = up_i ? (digit_q == DigMax) : (digit_q == '0);
    assign cout_o   = cin_i & at_limit;

    always_comb begin
        digit_d = digit_q;
        if (clear_i) begin
            digit_d = '0;
        end else if (load_i) begin
            digit_d = (load_val_i > DigMax) ? DigMax : load_val_i;
        end else if (cin_i) begin
            if (up_i) begin
                digit_d = at_limit ? '0 : digit_q + DIGIT_W'(1);
            end else begin
                digit_d = at_limit ? DigMax : digit_q - DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/digit_counter_scan.sv
// Multi-digit BCD/hex up/down counter stepped by a prescaler tick, with a
// free-running scan that time-multiplexes the digits onto one nibble bus and
// active-low one-cold digit enables for a shared 7-segment decoder.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    digit_counter_scan_if.slave (control in, count/wrap/display out)
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading-zero digits
// (digit 0 is never blanked).
module digit_counter_scan
    import counter_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned COUNT_HZ   = 1,
    parameter int unsigned SCAN_HZ    = 1000,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned RADIX      = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    digit_counter_scan_if.slave bus
);

    localparam int unsigned CountDiv = CLK_HZ / COUNT_HZ;
    localparam int unsigned ScanDiv  = CLK_HZ / SCAN_HZ;
    localparam int unsigned PreW     = div_width(CountDiv);
    localparam int unsigned ScanW    = div_width(ScanDiv);
    localparam int unsigned IdxW     = idx_width(NUM_DIGITS);

    localparam logic [PreW-1:0]  PreMax  = PreW'(CountDiv - 1);
    localparam logic [ScanW-1:0] ScanMax = ScanW'(ScanDiv - 1);
    localparam logic [IdxW-1:0]  IdxMax  = IdxW'(NUM_DIGITS - 1);

    if (!(RADIX == RADIX_BCD || RADIX == RADIX_HEX)) begin : g_bad_radix
        $error("digit_counter_scan: RADIX must be 10 or 16");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("digit_counter_scan: NUM_DIGITS must be 1..8");
    end
    if (CountDiv < 2 || (CLK_HZ % COUNT_HZ) != 0) begin : g_bad_count_div
        $error("digit_counter_scan: CLK_HZ/COUNT_HZ must be an integer >= 2");
    end
    if (ScanDiv < 2 || (CLK_HZ % SCAN_HZ) != 0) begin : g_bad_scan_div
        $error("digit_counter_scan: CLK_HZ/SCAN_HZ must be an integer >= 2");
    end

    // Count prescaler; clear/load restart it so the next step is a full period away.
    logic [PreW-1:0] pre_q, pre_d;
    logic            tick, step;

    assign tick = (pre_q == PreMax);
    assign step = tick & bus.en & ~bus.clear & ~bus.load;

    always_comb begin
        pre_d = pre_q;
        if (bus.clear || bus.load) begin
            pre_d = '0;
        end else if (bus.en) begin
            pre_d = tick ? '0 : pre_q + PreW'(1);
        end
    end

    // Digit chain: carry[0] is the step, carry[NUM_DIGITS] means the whole count rolled.
    logic [DIGIT_W-1:0]            digit [NUM_DIGITS];
    logic [NUM_DIGITS:0]           carry;
    logic [DIGIT_W*NUM_DIGITS-1:0] count_flat;

    assign carry[0] = step;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        counter_digit #(
            .RADIX (RADIX)
        ) u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear_i    (bus.clear),
            .load_i     (bus.load),
            .load_val_i (bus.load_val[i*DIGIT_W +: DIGIT_W]),
            .up_i       (bus.up_dn),
            .cin_i      (carry[i]),
            .digit_o    (digit[i]),
            .cout_o     (carry[i+1])
        );
        assign count_flat[i*DIGIT_W +: DIGIT_W] = digit[i];
    end

    logic wrap_q;

    // Scan prescaler and index, free-running regardless of en/clear/load.
    logic [ScanW-1:0] scan_q, scan_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             scan_tc;

    assign scan_tc = (scan_q == ScanMax);

    always_comb begin
        scan_d = scan_tc ? '0 : scan_q + ScanW'(1);
        idx_d  = idx_q;
        if (scan_tc) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
        end
    end

    // Display outputs: value and enable both come from idx_q so they move together.
    logic [DIGIT_W-1:0]    digit_val_q, digit_val_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;

`ifdef LEADING_ZERO_BLANK_EN
    // lead_zero[i]: digit i and every higher digit are zero.
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  run_zero;

    always_comb begin
        lead_zero = '0;
        run_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero     = run_zero & (digit[i] == '0);
            lead_zero[i] = run_zero;
        end
    end
`endif

    always_comb begin
        digit_val_d = '0;
        digit_sel_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                digit_val_d = digit[i];
`ifdef LEADING_ZERO_BLANK_EN
                digit_sel_d[i] = (i != 0) && lead_zero[i];
`else
                digit_sel_d[i] = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            wrap_q      <= 1'b0;
            scan_q      <= '0;
            idx_q       <= '0;
            digit_val_q <= '0;
            digit_sel_q <= '1;
        end else begin
            pre_q       <= pre_d;
            wrap_q      <= carry[NUM_DIGITS];
            scan_q      <= scan_d;
            idx_q       <= idx_d;
            digit_val_q <= digit_val_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign bus.count_val = count_flat;
    assign bus.wrap      = wrap_q;
    assign bus.digit_val = digit_val_q;
    assign bus.digit_sel = digit_sel_q;

endmodule

// File: tb/tb_digit_counter_scan.sv
// Directed bench for digit_counter_scan (4 BCD digits, tick every 10 cycles,
// scan step every 2 cycles). Expected values go into a scoreboard queue when
// the stimulus is applied and are popped when the DUT output is sampled.
// Honours LEADING_ZERO_BLANK_EN for the expected scan pattern.
module tb_digit_counter_scan;
    import counter_pkg::*;

    localparam int unsigned CLK_HZ     = 100;
    localparam int unsigned COUNT_HZ   = 10;
    localparam int unsigned SCAN_HZ    = 50;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned RADIX      = 10;

    logic clk = 1'b0;
    logic rst_n;

    digit_counter_scan_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    digit_counter_scan #(
        .CLK_HZ     (CLK_HZ),
        .COUNT_HZ   (COUNT_HZ),
        .SCAN_HZ    (SCAN_HZ),
        .NUM_DIGITS (NUM_DIGITS),
        .RADIX      (RADIX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic expect_v(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] exp_v;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load_val = v;
        bus.load     = 1'b1;
        cyc(1);
        bus.load     = 1'b0;
    endtask

    logic [3:0]  prev_sel;
    logic        found;
    logic [15:0] scan_cnt;
    logic [3:0]  exp_sel;
    int          slot;

    initial begin
        bus.en       = 1'b0;
        bus.up_dn    = 1'b1;
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;

        // Reset state
        cyc(1);
        expect_v(16'h0000); check("rst_count", bus.count_val);
        expect_v(16'h0000); check("rst_wrap", 16'(bus.wrap));
        expect_v(16'h0000); check("rst_digit_val", 16'(bus.digit_val));
        expect_v(16'h000F); check("rst_digit_sel", 16'(bus.digit_sel));

        // Count up 10 ticks: first step lands on the 10th edge
        rst_n  = 1'b1;
        bus.en = 1'b1;
        cyc(9);
        expect_v(16'h0000); check("up_before_tick1", bus.count_val);
        cyc(1);
        expect_v(16'h0001); check("up_tick1", bus.count_val);
        cyc(90);
        expect_v(16'h0010); check("up_tick10_carry", bus.count_val);
        expect_v(16'h0000); check("up_tick10_nowrap", 16'(bus.wrap));

        // Up wrap from 9999
        do_load(16'h9999);
        expect_v(16'h9999); check("load_9999", bus.count_val);
        cyc(9);
        expect_v(16'h9999); check("hold_before_wrap", bus.count_val);
        expect_v(16'h0000); check("no_wrap_before", 16'(bus.wrap));
        cyc(1);
        expect_v(16'h0000); check("up_wrap_count", bus.count_val);
        expect_v(16'h0001); check("up_wrap_pulse", 16'(bus.wrap));
        cyc(1);
        expect_v(16'h0000); check("up_wrap_one_cycle", 16'(bus.wrap));

        // Down wrap from 0000, then BCD clamp on load
        bus.up_dn = 1'b0;
        cyc(8);
        expect_v(16'h0000); check("down_before_tick", bus.count_val);
        cyc(1);
        expect_v(16'h9999); check("down_wrap_count", bus.count_val);
        expect_v(16'h0001); check("down_wrap_pulse", 16'(bus.wrap));
        cyc(1);
        expect_v(16'h0000); check("down_wrap_one_cycle", 16'(bus.wrap));
        do_load(16'h12AF);
        expect_v(16'h1299); check("load_clamp", bus.count_val);

        // clear + load on the tick cycle: step lost, prescaler restarts
        cyc(9);
        expect_v(16'h1299); check("pre_clear_hold", bus.count_val);
        bus.up_dn    = 1'b1;
        bus.clear    = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 16'h5555;
        cyc(1);
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
        expect_v(16'h0000); check("clear_beats_load_step", bus.count_val);
        expect_v(16'h0000); check("clear_no_wrap", 16'(bus.wrap));
        cyc(9);
        expect_v(16'h0000); check("clear_restart_hold", bus.count_val);
        cyc(1);
        expect_v(16'h0001); check("clear_restart_step", bus.count_val);

        // Scan pattern with a frozen count of 0305
        bus.en = 1'b0;
        do_load(16'h0305);
        cyc(3);
        scan_cnt = 16'h0305;
        prev_sel = bus.digit_sel;
        found    = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.digit_sel == 4'b1110 && prev_sel != 4'b1110) found = 1'b1;
            prev_sel = bus.digit_sel;
        end
        expect_v(16'h0001); check("scan_sync", 16'(found));
        for (int k = 0; k < 8; k++) begin
            slot    = k / 2;
            exp_sel = ~(4'b0001 << slot);
`ifdef LEADING_ZERO_BLANK_EN
            if (slot == 3) exp_sel = 4'b1111;
`endif
            expect_v(16'(exp_sel));
            expect_v(16'(scan_cnt[slot*4 +: 4]));
            check($sformatf("scan_sel_%0d", k), 16'(bus.digit_sel));
            check($sformatf("scan_val_%0d", k), 16'(bus.digit_val));
            cyc(1);
        end

        // Asynchronous reset mid-count
        bus.en    = 1'b1;
        bus.up_dn = 1'b1;
        do_load(16'h0042);
        cyc(3);
        expect_v(16'h0042); check("pre_reset_count", bus.count_val);
        #2 rst_n = 1'b0;
        #1;
        expect_v(16'h0000); check("async_rst_count", bus.count_val);
        expect_v(16'h000F); check("async_rst_sel", 16'(bus.digit_sel));
        expect_v(16'h0000); check("async_rst_wrap", 16'(bus.wrap));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(9);
        expect_v(16'h0000); check("post_rst_hold", bus.count_val);
        cyc(1);
        expect_v(16'h0001); check("post_rst_first_step", bus.count_val);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
